// File: rtl/decode_cycle.sv
// RV32I decode stage: main/ALU decode, 32x32 register file with writeback
// bypass, immediate extension and the ID/EX pipeline register.
module decode_cycle #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            RegWriteW,
   input  logic [4:0]      RDW,
   input  logic [XLEN-1:0] ResultW,
   input  logic            FlushE,
   output logic            RegWriteE,
   output logic [1:0]      ResultSrcE,
   output logic            MemWriteE,
   output logic            JumpE,
   output logic            BranchE,
   output logic            ALUSrcE,
   output logic [2:0]      ALUControlE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [4:0]      RS1E,
   output logic [4:0]      RS2E,
   output logic [4:0]      RDE,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [2:0] IMM_NONE = 3'd0;
   localparam logic [2:0] IMM_I    = 3'd1;
   localparam logic [2:0] IMM_S    = 3'd2;
   localparam logic [2:0] IMM_B    = 3'd3;
   localparam logic [2:0] IMM_J    = 3'd4;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   logic [XLEN-1:0] r_regs [NREGS];

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic            w_funct7b5;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [4:0]      w_rd;
   logic            w_wb_active;
   logic [XLEN-1:0] w_rd1;
   logic [XLEN-1:0] w_rd2;

   logic            w_reg_write;
   logic [1:0]      w_result_src;
   logic            w_mem_write;
   logic            w_jump;
   logic            w_branch;
   logic            w_alu_src;
   logic [2:0]      w_imm_src;
   logic [2:0]      w_alu_control;
   logic [XLEN-1:0] w_imm_ext;

   assign w_opcode   = InstrD[6:0];
   assign w_funct3   = InstrD[14:12];
   assign w_funct7b5 = InstrD[30];
   assign w_rs1      = InstrD[19:15];
   assign w_rs2      = InstrD[24:20];
   assign w_rd       = InstrD[11:7];

   // A writeback landing this edge is forwarded so decode never sees stale data.
   assign w_wb_active = RegWriteW && (RDW != 5'd0);

   always_comb begin
      w_rd1 = '0;
      if (w_wb_active && (RDW == w_rs1)) begin
         w_rd1 = ResultW;
      end else if (w_rs1 != 5'd0) begin
         w_rd1 = r_regs[w_rs1];
      end
   end

   always_comb begin
      w_rd2 = '0;
      if (w_wb_active && (RDW == w_rs2)) begin
         w_rd2 = ResultW;
      end else if (w_rs2 != 5'd0) begin
         w_rd2 = r_regs[w_rs2];
      end
   end

   always_comb begin
      w_reg_write  = 1'b0;
      w_result_src = 2'b00;
      w_mem_write  = 1'b0;
      w_jump       = 1'b0;
      w_branch     = 1'b0;
      w_alu_src    = 1'b0;
      w_imm_src    = IMM_NONE;
      case (w_opcode)
         OP_LW: begin
            w_reg_write  = 1'b1;
            w_result_src = 2'b01;
            w_alu_src    = 1'b1;
            w_imm_src    = IMM_I;
         end
         OP_SW: begin
            w_mem_write = 1'b1;
            w_alu_src   = 1'b1;
            w_imm_src   = IMM_S;
         end
         OP_R: begin
            w_reg_write = 1'b1;
         end
         OP_IALU: begin
            w_reg_write = 1'b1;
            w_alu_src   = 1'b1;
            w_imm_src   = IMM_I;
         end
         OP_BEQ: begin
            w_branch  = 1'b1;
            w_imm_src = IMM_B;
         end
         OP_JAL: begin
            w_reg_write  = 1'b1;
            w_result_src = 2'b10;
            w_jump       = 1'b1;
            w_imm_src    = IMM_J;
         end
         default: ;
      endcase
   end

   // Only R-type uses funct7[5]; addi with a negative immediate must stay add.
   always_comb begin
      w_alu_control = ALU_ADD;
      if (w_opcode == OP_BEQ) begin
         w_alu_control = ALU_SUB;
      end else if ((w_opcode == OP_R) || (w_opcode == OP_IALU)) begin
         case (w_funct3)
            3'b000: w_alu_control = ((w_opcode == OP_R) && w_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010: w_alu_control = ALU_SLT;
            3'b110: w_alu_control = ALU_OR;
            3'b111: w_alu_control = ALU_AND;
            default: w_alu_control = ALU_ADD;
         endcase
      end
   end

   always_comb begin
      w_imm_ext = '0;
      case (w_imm_src)
         IMM_I: w_imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
         IMM_S: w_imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B: w_imm_ext = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                             InstrD[30:25], InstrD[11:8], 1'b0};
         IMM_J: w_imm_ext = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12],
                             InstrD[20], InstrD[30:21], 1'b0};
         default: w_imm_ext = '0;
      endcase
   end

   // Reset clears every architectural register and drops a concurrent write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wb_active) begin
         r_regs[RDW] <= ResultW;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || FlushE) begin
         RegWriteE   <= 1'b0;
         ResultSrcE  <= 2'b00;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ALUControlE <= 3'b000;
         RD1E        <= '0;
         RD2E        <= '0;
         ImmExtE     <= '0;
         RS1E        <= 5'd0;
         RS2E        <= 5'd0;
         RDE         <= 5'd0;
         PCE         <= '0;
         PCPlus4E    <= '0;
      end else begin
         RegWriteE   <= w_reg_write;
         ResultSrcE  <= w_result_src;
         MemWriteE   <= w_mem_write;
         JumpE       <= w_jump;
         BranchE     <= w_branch;
         ALUSrcE     <= w_alu_src;
         ALUControlE <= w_alu_control;
         RD1E        <= w_rd1;
         RD2E        <= w_rd2;
         ImmExtE     <= w_imm_ext;
         RS1E        <= w_rs1;
         RS2E        <= w_rs2;
         RDE         <= w_rd;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
      end
   end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: each step pushes the expected ID/EX
// contents, clocks once, then pops and checks every output field.
module tb_decode_cycle;

   typedef struct packed {
      logic        regw;
      logic [1:0]  rsrc;
      logic        memw;
      logic        jmp;
      logic        br;
      logic        asrc;
      logic [2:0]  alu;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rdd;
      logic [31:0] pc;
      logic [31:0] pc4;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
   logic        RegWriteW, FlushE;
   logic [4:0]  RDW;
   logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]  RS1E, RS2E, RDE;

   exp_t exp_q[$];
   logic dc_q[$];
   int   total;
   int   bad;

   decode_cycle dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
      .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
      .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
      .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
      .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE), .PCE(PCE), .PCPlus4E(PCPlus4E)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                               input logic j, input logic b, input logic as,
                               input logic [2:0] alu, input logic [31:0] rd1,
                               input logic [31:0] rd2, input logic [31:0] imm,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] rdd, input logic [31:0] pc);
      exp_t e;
      e.regw = rw; e.rsrc = rs; e.memw = mw; e.jmp = j; e.br = b; e.asrc = as;
      e.alu = alu; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
      e.rs1 = r1; e.rs2 = r2; e.rdd = rdd; e.pc = pc; e.pc4 = pc + 32'd4;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_out(input string step_name);
      exp_t e;
      logic dc;
      total++;
      assert (exp_q.size() != 0) else begin
         bad++;
         $error("FAIL %s observed=empty_queue expected=entry", step_name);
      end
      if (exp_q.size() != 0) begin
         e  = exp_q.pop_front();
         dc = dc_q.pop_front();
         chk({step_name, ".RegWriteE"},   {31'd0, RegWriteE},   {31'd0, e.regw});
         chk({step_name, ".ResultSrcE"},  {30'd0, ResultSrcE},  {30'd0, e.rsrc});
         chk({step_name, ".MemWriteE"},   {31'd0, MemWriteE},   {31'd0, e.memw});
         chk({step_name, ".JumpE"},       {31'd0, JumpE},       {31'd0, e.jmp});
         chk({step_name, ".BranchE"},     {31'd0, BranchE},     {31'd0, e.br});
         if (!dc) chk({step_name, ".ALUSrcE"}, {31'd0, ALUSrcE}, {31'd0, e.asrc});
         chk({step_name, ".ALUControlE"}, {29'd0, ALUControlE}, {29'd0, e.alu});
         chk({step_name, ".RD1E"},        RD1E,                 e.rd1);
         chk({step_name, ".RD2E"},        RD2E,                 e.rd2);
         chk({step_name, ".ImmExtE"},     ImmExtE,              e.imm);
         chk({step_name, ".RS1E"},        {27'd0, RS1E},        {27'd0, e.rs1});
         chk({step_name, ".RS2E"},        {27'd0, RS2E},        {27'd0, e.rs2});
         chk({step_name, ".RDE"},         {27'd0, RDE},         {27'd0, e.rdd});
         chk({step_name, ".PCE"},         PCE,                  e.pc);
         chk({step_name, ".PCPlus4E"},    PCPlus4E,             e.pc4);
      end
   endtask

   // driver: apply inputs away from the edge, push expectation, clock, check
   task automatic step(input string name, input logic r, input logic [31:0] instr,
                       input logic [31:0] pc, input logic we, input logic [4:0] rd,
                       input logic [31:0] res, input logic fl, input exp_t e,
                       input logic asrc_dc);
      @(negedge clk);
      rst = r; InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
      RegWriteW = we; RDW = rd; ResultW = res; FlushE = fl;
      exp_q.push_back(e);
      dc_q.push_back(asrc_dc);
      @(posedge clk);
      #1;
      check_out(name);
   endtask

   localparam logic [31:0] ADD_3_5_6 = 32'h006281B3;
   localparam logic [31:0] SUB_3_5_6 = 32'h406281B3;
   localparam logic [31:0] SLT_3_5_6 = 32'h0062A1B3;
   localparam logic [31:0] LW_7      = 32'hFFC12383;
   localparam logic [31:0] ADD_3_0_0 = 32'h000001B3;
   localparam logic [31:0] ADD_3_5_0 = 32'h000281B3;
   localparam logic [31:0] ADD_3_7_0 = 32'h000381B3;
   localparam logic [31:0] SW_6_8_5  = 32'h0062A423;
   localparam logic [31:0] ORI_4_5   = 32'h0F02E213;
   localparam logic [31:0] BEQ_M8    = 32'hFE628CE3;
   localparam logic [31:0] JAL_1_16  = 32'h010000EF;

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b0; InstrD = '0; PCD = '0; PCPlus4D = '0;
      RegWriteW = 1'b0; RDW = '0; ResultW = '0; FlushE = 1'b0;

      // reset with a concurrent write to x5 that must be dropped
      step("reset0", 1'b0, ADD_3_5_6, 32'h40, 1'b1, 5'd5, 32'h55, 1'b0, '0, 1'b0);
      step("reset1", 1'b0, ADD_3_5_6, 32'h44, 1'b1, 5'd5, 32'h55, 1'b0, '0, 1'b0);
      step("x5_after_reset", 1'b1, ADD_3_5_6, 32'h48, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(1, 2'b00, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd5, 5'd6, 5'd3, 32'h48), 1'b0);

      // register writes with an unknown opcode in decode (bubble control)
      step("wr_x5", 1'b1, 32'h0, 32'h4C, 1'b1, 5'd5, 32'h11, 1'b0,
           mk(0, 2'b00, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h4C), 1'b0);
      step("wr_x6", 1'b1, 32'h0, 32'h50, 1'b1, 5'd6, 32'h22, 1'b0,
           mk(0, 2'b00, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h50), 1'b0);
      step("add_rtype", 1'b1, ADD_3_5_6, 32'h54, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(1, 2'b00, 0, 0, 0, 0, 3'b000, 32'h11, 32'h22, 32'h0, 5'd5, 5'd6, 5'd3, 32'h54), 1'b0);
      step("sub_rtype", 1'b1, SUB_3_5_6, 32'h58, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(1, 2'b00, 0, 0, 0, 0, 3'b001, 32'h11, 32'h22, 32'h0, 5'd5, 5'd6, 5'd3, 32'h58), 1'b0);
      step("slt_rtype", 1'b1, SLT_3_5_6, 32'h5C, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(1, 2'b00, 0, 0, 0, 0, 3'b101, 32'h11, 32'h22, 32'h0, 5'd5, 5'd6, 5'd3, 32'h5C), 1'b0);
      step("lw_negimm", 1'b1, LW_7, 32'h60, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(1, 2'b01, 0, 0, 0, 1, 3'b000, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd2, 5'd28, 5'd7, 32'h60), 1'b0);

      // same-cycle bypass, then x0 write ignored
      step("bypass_rs1", 1'b1, ADD_3_5_6, 32'h64, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0,
           mk(1, 2'b00, 0, 0, 0, 0, 3'b000, 32'hDEADBEEF, 32'h22, 32'h0, 5'd5, 5'd6, 5'd3, 32'h64), 1'b0);
      step("x0_write_bypass", 1'b1, ADD_3_0_0, 32'h68, 1'b1, 5'd0, 32'h12345678, 1'b0,
           mk(1, 2'b00, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3, 32'h68), 1'b0);
      step("x0_read_after", 1'b1, ADD_3_5_0, 32'h6C, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(1, 2'b00, 0, 0, 0, 0, 3'b000, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 5'd0, 5'd3, 32'h6C), 1'b0);
      step("ori_ialu", 1'b1, ORI_4_5, 32'h70, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(1, 2'b00, 0, 0, 0, 1, 3'b011, 32'hDEADBEEF, 32'h0, 32'h000000F0, 5'd5, 5'd16, 5'd4, 32'h70), 1'b0);

      // flush a store while a writeback to x7 still lands
      step("sw_flushed", 1'b1, SW_6_8_5, 32'h74, 1'b1, 5'd7, 32'h77, 1'b1, '0, 1'b0);
      step("sw_normal", 1'b1, SW_6_8_5, 32'h78, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(0, 2'b00, 1, 0, 0, 1, 3'b000, 32'hDEADBEEF, 32'h22, 32'h8, 5'd5, 5'd6, 5'd8, 32'h78), 1'b0);
      step("x7_after_flush", 1'b1, ADD_3_7_0, 32'h7C, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(1, 2'b00, 0, 0, 0, 0, 3'b000, 32'h77, 32'h0, 32'h0, 5'd7, 5'd0, 5'd3, 32'h7C), 1'b0);

      // branch and jump
      step("beq_m8", 1'b1, BEQ_M8, 32'h80, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(0, 2'b00, 0, 0, 1, 0, 3'b001, 32'hDEADBEEF, 32'h22, 32'hFFFFFFF8, 5'd5, 5'd6, 5'd25, 32'h80), 1'b0);
      step("jal_16", 1'b1, JAL_1_16, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(1, 2'b10, 0, 1, 0, 0, 3'b000, 32'h0, 32'h0, 32'h10, 5'd0, 5'd16, 5'd1, 32'h100), 1'b1);

      // mid-operation reset wipes the register file and the ID/EX contents
      step("reset_mid", 1'b0, ADD_3_5_6, 32'h104, 1'b1, 5'd9, 32'h99, 1'b0, '0, 1'b0);
      step("regs_after_reset", 1'b1, ADD_3_5_6, 32'h108, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(1, 2'b00, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd5, 5'd6, 5'd3, 32'h108), 1'b0);

      total++;
      assert (exp_q.size() == 0) else begin
         bad++;
         $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Second stage of the 5-stage RV32I pipeline; directly consumes the IF/ID outputs (InstrD, PCD, PCPlus4D) of the fetch stage.
- Decodes the instruction, reads the 32x32 register file and sign-extends the immediate.
- Captures everything into the ID/EX pipeline register feeding the execute stage.
- Register file writes come back from the writeback stage. FlushE inserts a bubble for taken branches and jumps.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, register file depth; address width is fixed at 5.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low.
- InstrD  in  32  instruction from IF/ID.
- PCD  in  32  PC of InstrD.
- PCPlus4D  in  32  PCD+4.
- RegWriteW  in  1  writeback write enable.
- RDW  in  5  writeback destination register.
- ResultW  in  32  writeback data.
- FlushE  in  1  load bubble into ID/EX.
- RegWriteE  out  1  register write enable.
- ResultSrcE  out  2  00=ALU, 01=memory, 10=PC+4.
- MemWriteE  out  1  store.
- JumpE  out  1  jal.
- BranchE  out  1  beq.
- ALUSrcE  out  1  1=immediate operand.
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- RD1E  out  32  rs1 data.
- RD2E  out  32  rs2 data.
- ImmExtE  out  32  sign-extended immediate.
- RS1E  out  5  rs1 field, for forwarding.
- RS2E  out  5  rs2 field, for forwarding.
- RDE  out  5  rd field.
- PCE  out  32  registered PCD.
- PCPlus4E  out  32  registered PCPlus4D.

Behaviour:
- Latency 1 cycle: fields decoded from InstrD in cycle N appear on the *E outputs after rising edge N+1.
- ID/EX update priority per rising edge: rst=0, then FlushE=1, then normal load.
- Reset: at the first rising edge with rst=0, all ID/EX outputs are 0 and all 32 architectural registers are 0. No asynchronous path exists; outputs keep their prior values until that edge.
- Reset mid-operation: any in-flight ID/EX contents are discarded at the reset edge, and any concurrent RegWriteW write is dropped.
- FlushE=1: all ID/EX outputs load 0, which is a bubble with no writes, branch or jump. The register file write in that cycle still occurs.
- Register file write: on rising edge when rst=1, RegWriteW=1 and RDW!=0, reg[RDW] <= ResultW.
- x0 always reads 0; writes to x0 are ignored.
- Register file read is combinational on rs1=InstrD[19:15] and rs2=InstrD[24:20].
- Same-cycle bypass: if RegWriteW=1, RDW!=0 and RDW equals rs1 (or rs2), that read returns ResultW.
- Main decode, control bundle {RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ImmSrc} by opcode:
  - 0000011 lw: 1, 01, 0, 0, 0, 1, I
  - 0100011 sw: 0, 00, 1, 0, 0, 1, S
  - 0110011 R-type: 1, 00, 0, 0, 0, 0, -
  - 0010011 I-ALU: 1, 00, 0, 0, 0, 1, I
  - 1100011 beq: 0, 00, 0, 0, 1, 0, B
  - 1101111 jal: 1, 10, 0, 1, 0, -, J
- Any other opcode produces all-zero control (bubble).
- ALU decode:
  - lw, sw, jal: add.
  - beq: sub.
  - R-type and I-ALU by funct3:
    - 000: sub only if R-type and funct7[5]=1, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - any other funct3: add.
- Immediate formats:
  - I: {20{i[31]}, i[31:20]}
  - S: {20{i[31]}, i[31:25], i[11:7]}
  - B: {19{i[31]}, i[31], i[7], i[30:25], i[11:8], 0}
  - J: {11{i[31]}, i[31], i[19:12], i[20], i[30:21], 0}
  - Opcodes with no immediate produce ImmExt=0.
- RS1E, RS2E and RDE are registered raw fields regardless of instruction type; they are 0 after reset or flush.

Test Plan:
1. Reset: rst=0 for 2 edges with RegWriteW=1, RDW=5 -> all *E outputs 0; later reading x5 returns 0.
2. R-type read: write x5=0x11 and x6=0x22, then InstrD=0x006281B3 (add x3,x5,x6) -> RD1E=0x11, RD2E=0x22, RDE=3, ALUControlE=000, RegWriteE=1, ALUSrcE=0.
3. Load with negative immediate: InstrD=0xFFC12383 (lw x7,-4(x2)) -> ImmExtE=0xFFFFFFFC, ResultSrcE=01, ALUSrcE=1, RegWriteE=1, RDE=7.
4. Bypass and x0:
   - RegWriteW=1, RDW=5, ResultW=0xDEADBEEF in the same cycle as add x3,x5,x6 -> RD1E=0xDEADBEEF.
   - RDW=0 write -> x0 still reads 0.
5. Flush: InstrD=sw with FlushE=1 -> MemWriteE=0 and all outputs 0. The next cycle with FlushE=0 loads normally.
6. Branch/jump decode:
   - beq with B-immediate -8 -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8.
   - jal -> JumpE=1, ResultSrcE=10, PCE and PCPlus4E equal the registered PCD and PCPlus4D.
